// File: rtl/wb_queue.sv
// wb_queue: write-back arbiter in front of the register-file write port.
// It merges the never-stalled pipeline write-back with long-latency results
// that arrive over a valid/ready handshake and wait in an in-order queue.
// Latency: pipeline writes 1 cycle; queued writes at least 2 cycles, with no bypass.
// Backpressure: lready drops when the queue holds DEPTH entries or while RST is high.
// Ports:
//   CLK, RST (async, active-high)
//   pWEN/pwsel/pwdat     pipeline write request, always accepted
//   lvalid/lready/lwsel/lwdat  long-latency result handshake
//   WEN/wsel/wdat        registered register-file write port
//   pending, busy_mask   hazard information from the valid queue entries
//   rsel, fwd_hit, fwd_dat  forwarding lookup, present only with WBQ_FWD_EN
// Optional feature macro: WBQ_FWD_EN (forwarding lookup). When it is not
// defined, fwd_hit and fwd_dat are tied to 0 and rsel is unused.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   pWEN,
  input  logic [REG_W-1:0]       pwsel,
  input  logic [WORD_W-1:0]      pwdat,
  input  logic                   lvalid,
  output logic                   lready,
  input  logic [REG_W-1:0]       lwsel,
  input  logic [WORD_W-1:0]      lwdat,
  output logic                   WEN,
  output logic [REG_W-1:0]       wsel,
  output logic [WORD_W-1:0]      wdat,
  output logic                   pending,
  output logic [(1<<REG_W)-1:0]  busy_mask,
  input  logic [REG_W-1:0]       rsel,
  output logic                   fwd_hit,
  output logic [WORD_W-1:0]      fwd_dat
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int NREG    = 1 << REG_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_sel_t;

  // Queue storage. A slot's valid bit is cleared when it is popped, so a set
  // valid bit always means an occupied, live entry.
  logic [DEPTH-1:0]   valid_q, valid_d;
  reg_sel_t           entry_wsel_q [DEPTH];
  word_t              entry_wdat_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [COUNT_W-1:0] count_q;

  logic     wen_q, wen_d;
  reg_sel_t wsel_q, wsel_d;
  word_t    wdat_q, wdat_d;

  logic p_eff, full, head_valid, head_stale, push, pop, emit_head;

  assign p_eff      = pWEN && (pwsel != '0);
  assign full       = (count_q == COUNT_W'(DEPTH));
  assign lready     = !full && !RST;
  assign head_valid = valid_q[head_q];
  assign head_stale = (count_q != '0) && !valid_q[head_q];
  // A result to register 0, or to the register the pipeline writes in the
  // same cycle, is accepted but never stored: it is already dead.
  assign push       = lvalid && lready && (lwsel != '0) && !(p_eff && (lwsel == pwsel));
  // A pipeline write takes the port, so a valid head must wait; a stale head
  // never needs the port and can be popped regardless.
  assign emit_head  = head_valid && !p_eff;
  assign pop        = head_stale || emit_head;

  always_comb begin
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (p_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_wsel_q[i] == pwsel) valid_d[i] = 1'b0;
      end
    end
    // The tail slot is free, so neither the pop nor the squash touches it.
    if (push) valid_d[tail_q] = 1'b1;
  end

  always_comb begin
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (p_eff) begin
      wen_d  = 1'b1;
      wsel_d = pwsel;
      wdat_d = pwdat;
    end else if (emit_head) begin
      wen_d  = 1'b1;
      wsel_d = entry_wsel_q[head_q];
      wdat_d = entry_wdat_q[head_q];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      wsel_q  <= '0;
      wdat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push) tail_q <= tail_q + PTR_W'(1);
      count_q <= count_q + COUNT_W'(push) - COUNT_W'(pop);
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
    end
  end

  // Payload needs no reset: it is only looked at behind a valid bit.
  always_ff @(posedge CLK) begin
    if (push) begin
      entry_wsel_q[tail_q] <= lwsel;
      entry_wdat_q[tail_q] <= lwdat;
    end
  end

  assign WEN  = wen_q;
  assign wsel = wsel_q;
  assign wdat = wdat_q;

  assign pending = |valid_q;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) busy_mask[entry_wsel_q[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

`ifdef WBQ_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk from oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (valid_q[fwd_idx] && (entry_wsel_q[fwd_idx] == rsel) && (rsel != '0)) begin
        fwd_hit = 1'b1;
        fwd_dat = entry_wdat_q[fwd_idx];
      end
    end
  end
`else
  logic unused_rsel;
  assign unused_rsel = ^rsel;
  assign fwd_hit     = 1'b0;
  assign fwd_dat     = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, pipeline passthrough, queue under
// contention, squash, register 0, pointer wrap, forwarding and mid-run reset.
module tb_wb_queue;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;
  localparam int NREG   = 1 << REG_W;

  logic              CLK, RST;
  logic              pWEN, lvalid, lready, WEN, pending, fwd_hit;
  logic [REG_W-1:0]  pwsel, lwsel, wsel, rsel;
  logic [WORD_W-1:0] pwdat, lwdat, wdat, fwd_dat;
  logic [NREG-1:0]   busy_mask;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_seen = 0;
  int bad11_seen = 0;
  int snap;

  wb_queue #(.DEPTH(4), .WORD_W(WORD_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST),
    .pWEN(pWEN), .pwsel(pwsel), .pwdat(pwdat),
    .lvalid(lvalid), .lready(lready), .lwsel(lwsel), .lwdat(lwdat),
    .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .pending(pending), .busy_mask(busy_mask),
    .rsel(rsel), .fwd_hit(fwd_hit), .fwd_dat(fwd_dat)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every cycle the register file would commit.
  always @(negedge CLK) begin
    if (WEN === 1'b1) begin
      wen_seen++;
      if (wdat === 32'h11) bad11_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %0b expected 0", WEN); end
    n_checks++; if (wsel !== 5'd0) begin n_fail++; $display("FAIL reset_wsel: got %0d expected 0", wsel); end
    n_checks++; if (wdat !== 32'd0) begin n_fail++; $display("FAIL reset_wdat: got %h expected 0", wdat); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b expected 0", pending); end
    n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    n_checks++; if (lready !== 1'b0) begin n_fail++; $display("FAIL reset_lready: got %0b expected 0", lready); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit: got %0b expected 0", fwd_hit); end
    n_checks++; if (fwd_dat !== 32'd0) begin n_fail++; $display("FAIL reset_fwd_dat: got %h expected 0", fwd_dat); end
    RST = 1'b0;
    #1;
    n_checks++; if (lready !== 1'b1) begin n_fail++; $display("FAIL reset_release_lready: got %0b expected 1", lready); end
    tick();
  endtask

  task automatic test_passthrough();
    pWEN = 1'b1; pwsel = 5'd5; pwdat = 32'hDEADBEEF;
    tick();
    pWEN = 1'b0;
    n_checks++; if (WEN !== 1'b1) begin n_fail++; $display("FAIL pass_wen: got %0b expected 1", WEN); end
    n_checks++; if (wsel !== 5'd5) begin n_fail++; $display("FAIL pass_wsel: got %0d expected 5", wsel); end
    n_checks++; if (wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pass_wdat: got %h expected deadbeef", wdat); end
    tick();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL pass_wen_drop: got %0b expected 0", WEN); end
    n_checks++; if (wsel !== 5'd5) begin n_fail++; $display("FAIL pass_wsel_hold: got %0d expected 5", wsel); end
  endtask

  task automatic test_contention();
    logic [NREG-1:0] exp_mask;
    exp_mask = '0;
    pWEN = 1'b1; pwsel = 5'd1; pwdat = 32'h0000_0001;
    for (int k = 0; k < 4; k++) begin
      lvalid = 1'b1; lwsel = REG_W'(2 + k); lwdat = 32'h100 + k;
      tick();
      exp_mask[2 + k] = 1'b1;
      n_checks++; if (WEN !== 1'b1 || wsel !== 5'd1) begin n_fail++; $display("FAIL cont_pipe_%0d: got wen=%0b wsel=%0d expected 1/1", k, WEN, wsel); end
      n_checks++; if (busy_mask !== exp_mask) begin n_fail++; $display("FAIL cont_busy_%0d: got %h expected %h", k, busy_mask, exp_mask); end
    end
    n_checks++; if (lready !== 1'b0) begin n_fail++; $display("FAIL cont_full_lready: got %0b expected 0", lready); end
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL cont_pending: got %0b expected 1", pending); end
    n_checks++; if (busy_mask !== 32'h3C) begin n_fail++; $display("FAIL cont_busy_full: got %h expected 3c", busy_mask); end
    // Offer another result while full: it must not enter.
    lwsel = 5'd6; lwdat = 32'h106;
    tick();
    n_checks++; if (busy_mask !== 32'h3C) begin n_fail++; $display("FAIL cont_no_push_full: got %h expected 3c", busy_mask); end
    lvalid = 1'b0; pWEN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (WEN !== 1'b1 || wsel !== REG_W'(2 + k) || wdat !== 32'h100 + k)
        begin n_fail++; $display("FAIL cont_drain_%0d: got wen=%0b wsel=%0d wdat=%h expected 1/%0d/%h", k, WEN, wsel, wdat, 2 + k, 32'h100 + k); end
      if (k == 0) begin
        n_checks++; if (lready !== 1'b1) begin n_fail++; $display("FAIL cont_lready_after_pop: got %0b expected 1", lready); end
      end
    end
    n_checks++; if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL cont_busy_empty: got %h expected 0", busy_mask); end
    tick();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL cont_idle_wen: got %0b expected 0", WEN); end
  endtask

  task automatic test_squash();
    pWEN = 1'b1; pwsel = 5'd1; pwdat = 32'h0;
    lvalid = 1'b1; lwsel = 5'd7; lwdat = 32'h11;
    tick();
    lwsel = 5'd8; lwdat = 32'h22;
    tick();
    n_checks++; if (busy_mask !== 32'h180) begin n_fail++; $display("FAIL sq_busy_before: got %h expected 180", busy_mask); end
    lvalid = 1'b0; pwsel = 5'd7; pwdat = 32'h99;
    tick();
    n_checks++; if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h99)
      begin n_fail++; $display("FAIL sq_pipe_write: got wen=%0b wsel=%0d wdat=%h expected 1/7/99", WEN, wsel, wdat); end
    n_checks++; if (busy_mask !== 32'h100) begin n_fail++; $display("FAIL sq_busy_after: got %h expected 100", busy_mask); end
    pWEN = 1'b0;
    tick();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL sq_stale_pop: got %0b expected 0", WEN); end
    tick();
    n_checks++; if (WEN !== 1'b1 || wsel !== 5'd8 || wdat !== 32'h22)
      begin n_fail++; $display("FAIL sq_reg8: got wen=%0b wsel=%0d wdat=%h expected 1/8/22", WEN, wsel, wdat); end
    tick();
    n_checks++; if (WEN !== 1'b0 || pending !== 1'b0) begin n_fail++; $display("FAIL sq_done: got wen=%0b pending=%0b expected 0/0", WEN, pending); end
    n_checks++; if (bad11_seen !== 0) begin n_fail++; $display("FAIL sq_no_0x11: got %0d writes of 0x11 expected 0", bad11_seen); end
    // Handshake to the register the pipeline writes in the same cycle is dropped.
    pWEN = 1'b1; pwsel = 5'd10; pwdat = 32'h55;
    lvalid = 1'b1; lwsel = 5'd10; lwdat = 32'h66;
    tick();
    lvalid = 1'b0; pWEN = 1'b0;
    n_checks++; if (WEN !== 1'b1 || wdat !== 32'h55) begin n_fail++; $display("FAIL sq_same_pipe: got wen=%0b wdat=%h expected 1/55", WEN, wdat); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL sq_same_drop: got pending=%0b expected 0", pending); end
    tick();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL sq_same_no_emit: got %0b expected 0", WEN); end
  endtask

  task automatic test_reg0();
    snap = wen_seen;
    pWEN = 1'b1; pwsel = 5'd0; pwdat = 32'hFF;
    lvalid = 1'b1; lwsel = 5'd0; lwdat = 32'hEE;
    tick();
    pWEN = 1'b0; lvalid = 1'b0;
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL r0_wen: got %0b expected 0", WEN); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL r0_pending: got %0b expected 0", pending); end
    n_checks++; if (lready !== 1'b1) begin n_fail++; $display("FAIL r0_lready: got %0b expected 1", lready); end
    tick(); tick();
    n_checks++; if (wen_seen !== snap) begin n_fail++; $display("FAIL r0_no_writes: got %0d writes expected 0", wen_seen - snap); end
    n_checks++; if (wsel !== 5'd10) begin n_fail++; $display("FAIL r0_wsel_hold: got %0d expected 10", wsel); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 12; k++) begin
      lvalid = 1'b1; lwsel = REG_W'(11 + k); lwdat = 32'h1000 + k;
      tick();
      n_checks++; if (lready !== 1'b1) begin n_fail++; $display("FAIL wrap_lready_%0d: got %0b expected 1", k, lready); end
      n_checks++; if (busy_mask !== (32'd1 << (11 + k))) begin n_fail++; $display("FAIL wrap_busy_%0d: got %h expected %h", k, busy_mask, 32'd1 << (11 + k)); end
      if (k == 0) begin
        n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL wrap_no_bypass: got %0b expected 0", WEN); end
      end else begin
        n_checks++; if (WEN !== 1'b1 || wsel !== REG_W'(10 + k) || wdat !== 32'h1000 + k - 1)
          begin n_fail++; $display("FAIL wrap_emit_%0d: got wen=%0b wsel=%0d wdat=%h expected 1/%0d/%h", k - 1, WEN, wsel, wdat, 10 + k, 32'h1000 + k - 1); end
      end
    end
    lvalid = 1'b0;
    tick();
    n_checks++; if (WEN !== 1'b1 || wsel !== 5'd22 || wdat !== 32'h100B)
      begin n_fail++; $display("FAIL wrap_emit_11: got wen=%0b wsel=%0d wdat=%h expected 1/22/100b", WEN, wsel, wdat); end
    tick();
    n_checks++; if (WEN !== 1'b0 || pending !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got wen=%0b pending=%0b expected 0/0", WEN, pending); end
  endtask

  task automatic test_fwd_and_reset();
    pWEN = 1'b1; pwsel = 5'd1; pwdat = 32'h77;
    lvalid = 1'b1; lwsel = 5'd9; lwdat = 32'hA;
    tick();
    lwdat = 32'hB;
    tick();
    lvalid = 1'b0; rsel = 5'd9;
    #1;
    n_checks++; if (busy_mask !== 32'h200 || pending !== 1'b1) begin n_fail++; $display("FAIL fwd_busy: got %h/%0b expected 200/1", busy_mask, pending); end
`ifdef WBQ_FWD_EN
    n_checks++; if (fwd_hit !== 1'b1 || fwd_dat !== 32'hB) begin n_fail++; $display("FAIL fwd_hit9: got %0b/%h expected 1/b", fwd_hit, fwd_dat); end
    rsel = 5'd3;
    #1;
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss3: got %0b expected 0", fwd_hit); end
`else
    n_checks++; if (fwd_hit !== 1'b0 || fwd_dat !== 32'd0) begin n_fail++; $display("FAIL fwd_disabled: got %0b/%h expected 0/0", fwd_hit, fwd_dat); end
`endif
    // Assert reset mid-cycle while a pipeline write is on the port.
    RST = 1'b1; rsel = 5'd9;
    #1;
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL rst_wen_async: got %0b expected 0", WEN); end
    n_checks++; if (pending !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL rst_queue: got %0b/%h expected 0/0", pending, busy_mask); end
    n_checks++; if (lready !== 1'b0) begin n_fail++; $display("FAIL rst_lready: got %0b expected 0", lready); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_hit: got %0b expected 0", fwd_hit); end
    pWEN = 1'b0;
    snap = wen_seen;
    tick();
    RST = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (wen_seen !== snap) begin n_fail++; $display("FAIL rst_no_writes: got %0d writes expected 0", wen_seen - snap); end
    n_checks++; if (pending !== 1'b0 || lready !== 1'b1) begin n_fail++; $display("FAIL rst_after: got pending=%0b lready=%0b expected 0/1", pending, lready); end
  endtask

  initial begin
    RST = 1'b1; pWEN = 1'b0; pwsel = '0; pwdat = '0;
    lvalid = 1'b0; lwsel = '0; lwdat = '0; rsel = '0;
    test_reset();
    test_passthrough();
    test_contention();
    test_squash();
    test_reg0();
    test_wrap();
    test_fwd_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
